// File: rtl/elevator_scheduler_if.sv
// Request/status bundle between the elevator car controller and its environment.
// The estop signal exists only when ELEV_ESTOP_EN is defined.
interface elevator_scheduler_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] req_in;
    logic [FLOOR_W-1:0]    cur_floor;
    logic [NUM_FLOORS-1:0] floor_onehot;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;
`ifdef ELEV_ESTOP_EN
    logic                  estop;

    modport master (
        output req_in, estop,
        input  cur_floor, floor_onehot, motor_up, motor_down, door_open, pending, busy
    );
    modport slave (
        input  req_in, estop,
        output cur_floor, floor_onehot, motor_up, motor_down, door_open, pending, busy
    );
`else
    modport master (
        output req_in,
        input  cur_floor, floor_onehot, motor_up, motor_down, door_open, pending, busy
    );
    modport slave (
        input  req_in,
        output cur_floor, floor_onehot, motor_up, motor_down, door_open, pending, busy
    );
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator car controller: latches floor calls, drives motor/door commands.
// Optional emergency stop is enabled by defining ELEV_ESTOP_EN.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_scheduler_if.slave  bus
);
    localparam int TMAX  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN} state_e;

    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    cur_q, cur_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;

    logic [NUM_FLOORS-1:0] cur_oh, up_oh, dn_oh, above_m, below_m;
    logic [NUM_FLOORS-1:0] req_lat, clr;
    logic                  any_above, any_below, ahead_up, ahead_dn, in_door, door_hit;
    logic                  halt;

`ifdef ELEV_ESTOP_EN
    assign halt = bus.estop;
`else
    assign halt = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign cur_oh[gi]  = (cur_q == FLOOR_W'(gi));
            assign above_m[gi] = (FLOOR_W'(gi) > cur_q);
            assign below_m[gi] = (FLOOR_W'(gi) < cur_q);
        end
    endgenerate

    // Neighbour floors as one-hot masks: the floor the car is about to arrive at.
    assign up_oh = {cur_oh[NUM_FLOORS-2:0], 1'b0};
    assign dn_oh = {1'b0, cur_oh[NUM_FLOORS-1:1]};

    assign any_above = |(pend_q & above_m);
    assign any_below = |(pend_q & below_m);
    assign ahead_up  = |(pend_q & above_m & ~up_oh);
    assign ahead_dn  = |(pend_q & below_m & ~dn_oh);

    // A call for the floor whose door is open extends the door instead of latching.
    assign in_door  = (state_q == S_DOOR_OPEN);
    assign door_hit = in_door & |(bus.req_in & cur_oh);
    assign req_lat  = bus.req_in & ~(in_door ? cur_oh : '0);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cur_d   = cur_q;
        tmr_d   = tmr_q;
        clr     = '0;
        if (!halt) begin
            unique case (state_q)
                S_IDLE: begin
                    if (|(pend_q & cur_oh)) begin
                        state_d = S_DOOR_OPEN;
                        tmr_d   = '0;
                        clr     = cur_oh;
                    end else if (any_above && (dir_q || !any_below)) begin
                        state_d = S_MOVE_UP;
                        dir_d   = 1'b1;
                        tmr_d   = '0;
                    end else if (any_below) begin
                        state_d = S_MOVE_DOWN;
                        dir_d   = 1'b0;
                        tmr_d   = '0;
                    end
                end
                S_MOVE_UP: begin
                    if (tmr_q == TRAVEL_LAST) begin
                        cur_d = cur_q + FLOOR_W'(1);
                        tmr_d = '0;
                        if (|(pend_q & up_oh)) begin
                            state_d = S_DOOR_OPEN;
                            clr     = up_oh;
                        end else if (!ahead_up) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                S_MOVE_DOWN: begin
                    if (tmr_q == TRAVEL_LAST) begin
                        cur_d = cur_q - FLOOR_W'(1);
                        tmr_d = '0;
                        if (|(pend_q & dn_oh)) begin
                            state_d = S_DOOR_OPEN;
                            clr     = dn_oh;
                        end else if (!ahead_dn) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                S_DOOR_OPEN: begin
                    if (door_hit) begin
                        tmr_d = '0;
                    end else if (tmr_q == DOOR_LAST) begin
                        state_d = S_IDLE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Clearing wins over a same-cycle call so the served floor never stays pending.
        pend_d = (pend_q | req_lat) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b1;
            cur_q   <= '0;
            pend_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.cur_floor    = cur_q;
    assign bus.floor_onehot = cur_oh;
    assign bus.pending      = pend_q;
    assign bus.motor_up     = (state_q == S_MOVE_UP) & ~halt;
    assign bus.motor_down   = (state_q == S_MOVE_DOWN) & ~halt;
    assign bus.door_open    = in_door;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: hand-derived vector table, corner sequences, and
// random calls checked every cycle against a countdown-based reference model.
module tb_elevator_scheduler;
    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   es_v = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: one mode plus a direction, floor as an int, countdown to the next event.
    int          m_st, m_f, m_dir, m_left;
    bit [NF-1:0] m_p;
    bit          m_es;

    task automatic model_reset();
        m_st = M_IDLE; m_f = 0; m_dir = 1; m_left = 0; m_p = '0; m_es = 1'b0;
    endtask

    function automatic bit any_beyond(input bit [NF-1:0] p, input int f, input int d);
        for (int j = 0; j < NF; j++)
            if (p[j] && (j - f) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit [NF-1:0] r, input bit es);
        bit [NF-1:0] p;
        bit [NF-1:0] np;
        p  = m_p;
        np = p | r;
        if (m_st == M_DOOR && r[m_f]) np[m_f] = 1'b0;
        m_es = es;
        if (!es) begin
            case (m_st)
                M_IDLE: begin
                    if (p[m_f]) begin
                        m_st = M_DOOR; m_left = DC; np[m_f] = 1'b0;
                    end else if (any_beyond(p, m_f, 1) && (m_dir == 1 || !any_beyond(p, m_f, -1))) begin
                        m_st = M_MOVE; m_dir = 1; m_left = TC;
                    end else if (any_beyond(p, m_f, -1)) begin
                        m_st = M_MOVE; m_dir = -1; m_left = TC;
                    end
                end
                M_MOVE: begin
                    if (m_left > 1) m_left--;
                    else begin
                        m_f += m_dir;
                        if (p[m_f]) begin
                            m_st = M_DOOR; m_left = DC; np[m_f] = 1'b0;
                        end else if (any_beyond(p, m_f, m_dir)) m_left = TC;
                        else m_st = M_IDLE;
                    end
                end
                default: begin
                    if (r[m_f]) m_left = DC;
                    else if (m_left > 1) m_left--;
                    else m_st = M_IDLE;
                end
            endcase
        end
        m_p = np;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("m_floor",   32'(bus.cur_floor), 32'(m_f));
        chk("m_onehot",  32'(bus.floor_onehot), 32'(1) << m_f);
        chk("m_up",      32'(bus.motor_up), 32'(m_st == M_MOVE && m_dir == 1 && !m_es));
        chk("m_down",    32'(bus.motor_down), 32'(m_st == M_MOVE && m_dir == -1 && !m_es));
        chk("m_door",    32'(bus.door_open), 32'(m_st == M_DOOR));
        chk("m_pending", 32'(bus.pending), 32'(m_p));
        chk("m_busy",    32'(bus.busy), 32'(m_st != M_IDLE));
    endtask

    task automatic cyc(input logic [NF-1:0] r);
        bus.req_in = r;
`ifdef ELEV_ESTOP_EN
        bus.estop = es_v;
`endif
        @(posedge clk);
        model_step(r, es_v);
        #1;
        $display("cyc req=%02h floor=%0d up=%0b dn=%0b door=%0b pend=%02h",
                 r, bus.cur_floor, bus.motor_up, bus.motor_down, bus.door_open, bus.pending);
        compare_model();
    endtask

    typedef struct {
        logic [NF-1:0] req;
        int            n;
        int            fl;
        logic          up;
        logic          dn;
        logic          door;
        logic [NF-1:0] pend;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int cnt;
        bit ok;
        logic [FW-1:0] saved;

        // Single call to floor 3, then calls at 0/3/4 with the car idle at floor 3 heading up.
        tbl[0]  = '{8'h08, 1, 0, 1'b0, 1'b0, 1'b0, 8'h08};
        tbl[1]  = '{8'h00, 4, 0, 1'b1, 1'b0, 1'b0, 8'h08};
        tbl[2]  = '{8'h00, 4, 1, 1'b1, 1'b0, 1'b0, 8'h08};
        tbl[3]  = '{8'h00, 4, 2, 1'b1, 1'b0, 1'b0, 8'h08};
        tbl[4]  = '{8'h00, 3, 3, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[5]  = '{8'h00, 2, 3, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{8'h19, 1, 3, 1'b0, 1'b0, 1'b0, 8'h19};
        tbl[7]  = '{8'h00, 3, 3, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[8]  = '{8'h00, 1, 3, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[9]  = '{8'h00, 4, 3, 1'b1, 1'b0, 1'b0, 8'h11};
        tbl[10] = '{8'h00, 3, 4, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[11] = '{8'h00, 1, 4, 1'b0, 1'b0, 1'b0, 8'h01};
        tbl[12] = '{8'h00, 4, 4, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[13] = '{8'h00, 4, 3, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[14] = '{8'h00, 4, 2, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[15] = '{8'h00, 4, 1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[16] = '{8'h00, 3, 0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[17] = '{8'h00, 2, 0, 1'b0, 1'b0, 1'b0, 8'h00};

        bus.req_in = '0;
`ifdef ELEV_ESTOP_EN
        bus.estop = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_floor",  32'(bus.cur_floor), 32'd0);
        chk("rst_onehot", 32'(bus.floor_onehot), 32'h01);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc('0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc(tbl[i].req);
                chk($sformatf("t%0d_floor", i), 32'(bus.cur_floor), 32'(tbl[i].fl));
                chk($sformatf("t%0d_up", i),    32'(bus.motor_up), 32'(tbl[i].up));
                chk($sformatf("t%0d_dn", i),    32'(bus.motor_down), 32'(tbl[i].dn));
                chk($sformatf("t%0d_door", i),  32'(bus.door_open), 32'(tbl[i].door));
                chk($sformatf("t%0d_pend", i),  32'(bus.pending), 32'(tbl[i].pend));
            end
        end

        // Reset asserted asynchronously while travelling up past floor 2.
        cyc(8'h20);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.cur_floor == 3'd2 && bus.motor_up) begin ok = 1'b1; break; end
            cyc('0);
        end
        chk("reach_floor2", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_floor",  32'(bus.cur_floor), 32'd0);
        chk("arst_onehot", 32'(bus.floor_onehot), 32'h01);
        chk("arst_pend",   32'(bus.pending), 32'd0);
        chk("arst_cmds",   32'({bus.motor_up, bus.motor_down, bus.door_open, bus.busy}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc('0);

        // A repeat call for floor 2 during the second door cycle restarts the door timer: 2 + 3 cycles.
        cyc(8'h04);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.door_open) begin ok = 1'b1; break; end
            cyc('0);
        end
        chk("door_reached", 32'(ok), 32'd1);
        cnt = 1;
        cyc('0);
        if (bus.door_open) cnt++;
        cyc(8'h04);
        if (bus.door_open) cnt++;
        chk("door_ext_pend2", 32'(bus.pending[2]), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc('0);
            if (!bus.door_open) break;
            cnt++;
        end
        chk("door_ext_len", 32'(cnt), 32'd5);

`ifdef ELEV_ESTOP_EN
        // Freeze two cycles into a hop; the remaining two travel cycles follow the release.
        cyc(8'h80);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.motor_up) begin ok = 1'b1; break; end
            cyc('0);
        end
        chk("estop_move", 32'(ok), 32'd1);
        cyc('0);
        cyc('0);
        saved = bus.cur_floor;
        es_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc('0);
            chk("estop_motor", 32'({bus.motor_up, bus.motor_down}), 32'd0);
            chk("estop_floor", 32'(bus.cur_floor), 32'(saved));
        end
        es_v = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc('0);
            cnt++;
            if (bus.cur_floor != saved) break;
        end
        chk("estop_resume", 32'(cnt), 32'(TC - 2));
`else
        saved = '0;
`endif

        // Random sparse calls, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [NF-1:0] r;
            r = '0;
            if ($urandom_range(0, 7) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
            if ($urandom_range(0, 40) == 0) r = NF'($urandom);
`ifdef ELEV_ESTOP_EN
            es_v = ($urandom_range(0, 15) == 0);
`endif
            cyc(r);
            chk("excl_motors", 32'(bus.motor_up & bus.motor_down), 32'd0);
            chk("door_vs_motor", 32'(bus.door_open & (bus.motor_up | bus.motor_down)), 32'd0);
        end
        es_v = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
